// File: rtl/jump_sequencer.sv
// -----------------------------------------------------------------------------
// jump_sequencer
// Per-frame controller for the doodle vertical datapath. Owns the game state
// (IDLE/RISE/FALL/DEAD), the velocity profile (jump impulse, gravity, terminal
// fall speed) and platform landing. Each frame it either issues a Y delta for
// the doodle or converts upward motion above the camera line into world
// scroll, accumulates the score and raises game over.
//
// Ports:
//   Clk           in   system clock
//   Reset         in   asynchronous, active-low reset
//   frame_tick    in   one-Clk pulse per video frame
//   start         in   level start/restart request
//   pause         in   level pause (only with JUMP_SEQ_PAUSE_EN defined)
//   doodle_y      in   [9:0] current doodle centre Y, unsigned
//   plat_hit      in   doodle feet overlap a platform (sampled on tick)
//   vel_y         out  [9:0] two's-complement Y delta for this frame
//   y_apply       out  strobe: datapath adds vel_y to doodle_y
//   scroll_amt    out  [9:0] unsigned world scroll in px
//   scroll_valid  out  strobe: platforms shift down by scroll_amt
//   loadplat      out  strobe: platform generator reloads initial layout
//   score         out  [15:0] accumulated scroll distance (saturating)
//   game_over     out  high while in DEAD
//   state         out  [1:0] IDLE=0, RISE=1, FALL=2, DEAD=3
//
// Optional feature: define JUMP_SEQ_PAUSE_EN to add the pause input. While
// pause is high, frame ticks are dropped, so velocity, score and state hold.
// -----------------------------------------------------------------------------
module jump_sequencer #(
  parameter int JUMP_VEL      = 12,
  parameter int GRAVITY       = 1,
  parameter int MAX_FALL      = 10,
  parameter int SCROLL_LINE   = 160,
  parameter int SCREEN_BOTTOM = 479,
  parameter int DOODLE_SIZE   = 12
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        frame_tick,
  input  logic        start,
`ifdef JUMP_SEQ_PAUSE_EN
  input  logic        pause,
`endif
  input  logic [9:0]  doodle_y,
  input  logic        plat_hit,
  output logic [9:0]  vel_y,
  output logic        y_apply,
  output logic [9:0]  scroll_amt,
  output logic        scroll_valid,
  output logic        loadplat,
  output logic [15:0] score,
  output logic        game_over,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RISE = 2'd1,
    FALL = 2'd2,
    DEAD = 2'd3
  } state_t;

  localparam logic signed [10:0] JUMP_S = 11'(JUMP_VEL);
  localparam logic signed [10:0] GRAV_S = 11'(GRAVITY);
  localparam logic signed [10:0] MAXF_S = 11'(MAX_FALL);
  localparam logic signed [10:0] LINE_S = 11'(SCROLL_LINE);
  localparam logic        [11:0] BOT_U  = 12'(SCREEN_BOTTOM);
  localparam logic        [11:0] DSZ_U  = 12'(DOODLE_SIZE);

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [9:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {7'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  state_t             cur, nxt;
  logic signed [10:0] v, v_nxt;
  logic        [9:0]  vel_nxt, amt_nxt;
  logic               apply_nxt, sv_nxt, lp_nxt, go_nxt;
  logic        [15:0] score_nxt;

  logic               tick;
  logic signed [10:0] y_ext, ny, v_grav, v_upd;
  logic               bottom;

`ifdef JUMP_SEQ_PAUSE_EN
  assign tick = frame_tick & ~pause;
`else
  assign tick = frame_tick;
`endif

  assign y_ext  = signed'({1'b0, doodle_y});
  assign ny     = y_ext + v;
  assign v_grav = v + GRAV_S;
  assign v_upd  = (v_grav > MAXF_S) ? MAXF_S : v_grav;
  assign bottom = ({2'b00, doodle_y} + DSZ_U) >= BOT_U;
  assign state  = cur;

  always_comb begin
    nxt       = cur;
    v_nxt     = v;
    vel_nxt   = vel_y;
    amt_nxt   = scroll_amt;
    apply_nxt = 1'b0;
    sv_nxt    = 1'b0;
    lp_nxt    = 1'b0;
    score_nxt = score;
    go_nxt    = game_over;
    case (cur)
      IDLE, DEAD: begin
        // start has priority over a coincident tick; the tick is dropped.
        if (start) begin
          nxt       = RISE;
          v_nxt     = -JUMP_S;
          vel_nxt   = '0;
          amt_nxt   = '0;
          score_nxt = '0;
          go_nxt    = 1'b0;
          lp_nxt    = 1'b1;
        end
      end
      RISE, FALL: begin
        if (tick) begin
          if (cur == FALL && plat_hit) begin
            // Landing wins over bottom-out; no gravity on this frame.
            nxt       = RISE;
            v_nxt     = -JUMP_S;
            vel_nxt   = '0;
            amt_nxt   = '0;
            apply_nxt = 1'b1;
          end else if (cur == FALL && bottom) begin
            nxt     = DEAD;
            v_nxt   = '0;
            vel_nxt = '0;
            amt_nxt = '0;
            go_nxt  = 1'b1;
          end else begin
            apply_nxt = 1'b1;
            if (v < 0 && ny < LINE_S) begin
              // Motion past the camera line becomes world scroll; the doodle
              // only moves the part of the step that is still below the line.
              sv_nxt = 1'b1;
              if (y_ext >= LINE_S) begin
                vel_nxt = 10'(LINE_S - y_ext);
                amt_nxt = 10'(-v - (y_ext - LINE_S));
              end else begin
                vel_nxt = '0;
                amt_nxt = 10'(-v);
              end
              score_nxt = sat_add(score, amt_nxt);
            end else begin
              vel_nxt = 10'(v);
              amt_nxt = '0;
            end
            v_nxt = v_upd;
            if (cur == RISE && v_upd >= 0) nxt = FALL;
          end
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // Frame-decision register stage: every output is registered here.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cur          <= IDLE;
      v            <= '0;
      vel_y        <= '0;
      y_apply      <= 1'b0;
      scroll_amt   <= '0;
      scroll_valid <= 1'b0;
      loadplat     <= 1'b0;
      score        <= '0;
      game_over    <= 1'b0;
    end else begin
      cur          <= nxt;
      v            <= v_nxt;
      vel_y        <= vel_nxt;
      y_apply      <= apply_nxt;
      scroll_amt   <= amt_nxt;
      scroll_valid <= sv_nxt;
      loadplat     <= lp_nxt;
      score        <= score_nxt;
      game_over    <= go_nxt;
    end
  end

endmodule

// File: doc/jump_sequencer.md
Name: jump_sequencer

Overview:
- Per-frame game controller for the doodle vertical datapath.
- Owns the game state, the doodle velocity profile (jump impulse, gravity, terminal fall speed) and platform landing.
- Decides each frame whether to move the doodle or scroll the world (camera line), keeps the score, and raises game over.
- Sits between the collision/platform logic and the position registers; the position datapath only applies the deltas this block issues.

Parameters:
- JUMP_VEL, 12, jump impulse magnitude in px/frame (applied upward, as a negative velocity).
- GRAVITY, 1, velocity increment per frame.
- MAX_FALL, 10, terminal downward velocity.
- SCROLL_LINE, 160, topmost Y the doodle may reach; motion above it becomes world scroll.
- SCREEN_BOTTOM, 479, last visible row.
- DOODLE_SIZE, 12, doodle half-height used for the bottom-out test.

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-low reset
- frame_tick  in  1  one-Clk pulse per video frame
- start  in  1  level, start/restart request (decoded key)
- doodle_y  in  10  current doodle centre Y, unsigned
- plat_hit  in  1  doodle feet overlap a platform; sampled on frame_tick
- vel_y  out  10  two's-complement Y delta for this frame
- y_apply  out  1  one-cycle strobe: datapath adds vel_y to doodle_y
- scroll_amt  out  10  unsigned world scroll in px
- scroll_valid  out  1  one-cycle strobe: platforms shift down by scroll_amt
- loadplat  out  1  one-cycle strobe: platform generator reloads its initial layout
- score  out  16  accumulated scroll distance
- game_over  out  1  high while in DEAD
- state  out  2  IDLE=0, RISE=1, FALL=2, DEAD=3

Behaviour:
- Reset (async, active-low):
  - state = IDLE; internal velocity v = 0.
  - All outputs 0.
  - Reset asserted mid-frame forces these values immediately; no partial strobes.
- All outputs are registered. Per-frame responses appear the cycle after frame_tick; y_apply and scroll_valid are high for exactly that one cycle.
- IDLE, or DEAD, with start=1:
  - Next cycle: state = RISE, v = -JUMP_VEL, score = 0, game_over = 0.
  - loadplat pulses for 1 cycle.
  - start in RISE or FALL is ignored.
- On frame_tick in RISE or FALL, compute ny = doodle_y + v in 11-bit signed arithmetic.
  - Scroll case, v < 0 and ny < SCROLL_LINE:
    - If doodle_y >= SCROLL_LINE: vel_y = SCROLL_LINE - doodle_y and scroll_amt = -v - (doodle_y - SCROLL_LINE).
    - Otherwise: vel_y = 0 and scroll_amt = -v.
    - scroll_valid = 1; score += scroll_amt, saturating at 0xFFFF.
  - Normal case: vel_y = v, scroll_amt = 0, scroll_valid = 0.
  - y_apply = 1 in both cases.
  - Velocity update: v = min(v + GRAVITY, MAX_FALL), signed compare.
- RISE -> FALL: on the tick where the updated v >= 0. plat_hit is ignored in RISE.
- FALL with plat_hit=1 on tick (landing):
  - vel_y = 0, y_apply = 1.
  - v = -JUMP_VEL; state = RISE.
  - No gravity is applied on this tick.
- FALL with doodle_y + DOODLE_SIZE >= SCREEN_BOTTOM on tick and plat_hit=0:
  - state = DEAD, game_over = 1, v = 0.
  - y_apply = 0, vel_y = 0.
- Simultaneous plat_hit and bottom-out: landing wins.
- frame_tick in IDLE or DEAD: no strobes; vel_y holds 0.
- start and frame_tick in the same cycle in IDLE/DEAD: start wins; the tick is dropped.

Optional Feature:
- Macro: JUMP_SEQ_PAUSE_EN.
- Defined:
  - Adds input pause (1 bit, level).
  - While pause=1 in RISE or FALL: frame_tick is ignored, v, score and state hold, and no strobes are issued.
  - start remains ignored while paused.
  - Releasing pause resumes on the next frame_tick.
- Undefined: the port is absent and behaviour is as above.

Test Plan:
- Start from IDLE: Reset released, doodle_y=300, start=1 -> next cycle loadplat=1 for 1 cycle, state=1, score=0. First frame_tick -> next cycle vel_y=0x3F4 (-12), y_apply=1.
- Apex and terminal speed: 12 ticks from start -> state=2 with vel_y sequence -12..-1. Continue ticking (no hit, doodle_y=200) -> vel_y climbs 0..10, then stays 10.
- Scroll split: RISE, v=-12, doodle_y=165 -> vel_y=-5, scroll_amt=7, scroll_valid=1, score+=7. Next tick with doodle_y=160, v=-11 -> vel_y=0, scroll_amt=11.
- Landing: FALL, v=6, plat_hit=1 on tick -> vel_y=0, state=1. Next tick vel_y=-12.
- Death and priority: FALL, doodle_y=470, plat_hit=0 -> state=3, game_over=1, y_apply=0. Repeat with plat_hit=1 -> state=1, game_over=0. From DEAD, start=1 -> loadplat pulse, score=0.
- Async reset: assert Reset=0 mid-RISE between clocks -> state=0, all outputs 0 before the next Clk edge. With JUMP_SEQ_PAUSE_EN and pause=1 -> 5 ticks produce no y_apply and score unchanged.
